// File: rtl/decode_pkg.sv
// ---------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the byte-serial x86 decoder:
//   - primary opcode constants of the supported ADD/OR/SHR/JMP subset
//   - decoder FSM state encoding
//   - ALU control (aluk) encodings driven to the AGEX stage
//   - immediate/displacement size codes (byte counts) and maximum length
// ---------------------------------------------------------------------------
package decode_pkg;

    // Primary opcodes
    localparam logic [7:0] OPC_ADD_MR      = 8'h01;
    localparam logic [7:0] OPC_ADD_RM      = 8'h03;
    localparam logic [7:0] OPC_ADD_EAX_I32 = 8'h05;
    localparam logic [7:0] OPC_OR_MR       = 8'h09;
    localparam logic [7:0] OPC_OR_RM       = 8'h0B;
    localparam logic [7:0] OPC_OR_EAX_I32  = 8'h0D;
    localparam logic [7:0] OPC_GRP1_I32    = 8'h81;
    localparam logic [7:0] OPC_GRP1_I8     = 8'h83;
    localparam logic [7:0] OPC_GRP2_I8     = 8'hC1;
    localparam logic [7:0] OPC_JMP_REL32   = 8'hE9;
    localparam logic [7:0] OPC_JMP_REL8    = 8'hEB;

    // Field sizes, expressed directly as the number of bytes to collect
    localparam logic [2:0] SZ_NONE = 3'd0;
    localparam logic [2:0] SZ_8    = 3'd1;
    localparam logic [2:0] SZ_32   = 3'd4;

    // Longest legal instruction: opcode + ModR/M + disp32 + imm32
    localparam logic [3:0] MAX_LEN = 4'd10;

    typedef enum logic [2:0] {
        S_OPC   = 3'd0,
        S_MODRM = 3'd1,
        S_DISP  = 3'd2,
        S_IMM   = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_OR  = 2'b01,
        ALU_SHR = 2'b11
    } aluk_t;

endpackage

// File: rtl/x86_opcode_lut.sv
// ---------------------------------------------------------------------------
// x86_opcode_lut
// Combinational opcode table for the decoder.
//   opcode     in  8  primary opcode byte
//   reg_field  in  3  ModR/M.reg (opcode extension for group opcodes)
//   has_modrm  out 1  opcode is followed by a ModR/M byte
//   imm_sz     out 3  immediate bytes (0/1/4)
//   disp_sz    out 3  displacement bytes for opcodes without ModR/M (0/1/4)
//   aluk       out 2  ALU control
//   is_jmp     out 1  relative jump
//   opc_known  out 1  opcode belongs to the supported subset
//   reg_ok     out 1  opcode known and the /reg extension is allowed
// ---------------------------------------------------------------------------
module x86_opcode_lut
    import decode_pkg::*;
(
    input  logic [7:0] opcode,
    input  logic [2:0] reg_field,
    output logic       has_modrm,
    output logic [2:0] imm_sz,
    output logic [2:0] disp_sz,
    output aluk_t      aluk,
    output logic       is_jmp,
    output logic       opc_known,
    output logic       reg_ok
);

    always_comb begin
        has_modrm = 1'b0;
        imm_sz    = SZ_NONE;
        disp_sz   = SZ_NONE;
        aluk      = ALU_ADD;
        is_jmp    = 1'b0;
        opc_known = 1'b1;
        reg_ok    = 1'b1;
        unique case (opcode)
            OPC_ADD_MR, OPC_ADD_RM: begin
                has_modrm = 1'b1;
            end
            OPC_OR_MR, OPC_OR_RM: begin
                has_modrm = 1'b1;
                aluk      = ALU_OR;
            end
            OPC_ADD_EAX_I32: begin
                imm_sz = SZ_32;
            end
            OPC_OR_EAX_I32: begin
                imm_sz = SZ_32;
                aluk   = ALU_OR;
            end
            // Group 1: /0 is add, /1 is or; other extensions unsupported
            OPC_GRP1_I32, OPC_GRP1_I8: begin
                has_modrm = 1'b1;
                imm_sz    = (opcode == OPC_GRP1_I32) ? SZ_32 : SZ_8;
                aluk      = (reg_field == 3'd1) ? ALU_OR : ALU_ADD;
                reg_ok    = (reg_field == 3'd0) || (reg_field == 3'd1);
            end
            // Group 2: only /5 (shr) is supported
            OPC_GRP2_I8: begin
                has_modrm = 1'b1;
                imm_sz    = SZ_8;
                aluk      = ALU_SHR;
                reg_ok    = (reg_field == 3'd5);
            end
            OPC_JMP_REL8: begin
                disp_sz = SZ_8;
                is_jmp  = 1'b1;
            end
            OPC_JMP_REL32: begin
                disp_sz = SZ_32;
                is_jmp  = 1'b1;
            end
            default: begin
                opc_known = 1'b0;
                reg_ok    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/x86_byte_decoder.sv
// ---------------------------------------------------------------------------
// x86_byte_decoder
// Byte-serial x86 decoder for the ADD/OR/SHR/JMP subset executed by AGEX.
// One instruction byte is consumed per cycle; one bundle is produced per
// instruction and held until AGEX accepts it.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_byte/in_valid    fetch byte stream        in_ready  decoder can take it
//   out_valid           bundle valid             out_ready AGEX takes it
//   opcode, modrm       raw opcode / ModR/M (modrm 0 when absent)
//   disp, imm           32-bit fields; 8-bit forms sit in [31:24]
//   disp_is8, imm_is8   field is the 8-bit form
//   aluk                00 add, 01 or, 11 shift right
//   is_jmp              relative jump, offset carried in disp
//   len                 instruction length in bytes (1..10)
//   illegal             unsupported encoding (only with DECODE_ILLEGAL_EN)
//
// Build option DECODE_ILLEGAL_EN: when defined, an unsupported encoding is
// emitted as a bundle with illegal=1 right after the offending byte; when
// undefined, such an instruction is dropped and decoding restarts at the
// next byte, which is treated as an opcode.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready depends only on the FSM state (never on in_valid), and
// out_valid, once raised, stays high with a stable bundle until out_ready.
// ---------------------------------------------------------------------------
module x86_byte_decoder
    import decode_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  opcode,
    output logic [7:0]  modrm,
    output logic [31:0] disp,
    output logic [31:0] imm,
    output logic        disp_is8,
    output logic        imm_is8,
    output logic [1:0]  aluk,
    output logic        is_jmp,
    output logic [3:0]  len
`ifdef DECODE_ILLEGAL_EN
    ,
    output logic        illegal
`endif
);

    state_t      state_q, state_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [7:0]  modrm_q, modrm_d;
    logic [31:0] disp_q, disp_d;
    logic [31:0] imm_q, imm_d;
    logic        disp_is8_q, disp_is8_d;
    logic        imm_is8_q, imm_is8_d;
    aluk_t       aluk_q, aluk_d;
    logic        is_jmp_q, is_jmp_d;
    logic [3:0]  len_q, len_d;
    logic [2:0]  cnt_q, cnt_d;            // bytes left in the current field
    logic [2:0]  pend_imm_q, pend_imm_d;  // immediate still owed after ModR/M/disp
`ifdef DECODE_ILLEGAL_EN
    logic        illegal_q, illegal_d;
`endif

    logic        accept;
    logic [7:0]  lut_opcode;
    logic        lut_has_modrm;
    logic [2:0]  lut_imm_sz;
    logic [2:0]  lut_disp_sz;
    aluk_t       lut_aluk;
    logic        lut_is_jmp;
    logic        lut_known;
    logic        lut_reg_ok;
    logic        sib;
    logic [2:0]  modrm_disp_sz;

    assign in_ready = (state_q != S_OUT);
    assign accept   = in_valid && in_ready;

    // In OPC the incoming byte is the opcode; afterwards the latched one is
    // looked up together with the incoming ModR/M.reg.
    assign lut_opcode = (state_q == S_OPC) ? in_byte : opcode_q;

    x86_opcode_lut u_lut (
        .opcode    (lut_opcode),
        .reg_field (in_byte[5:3]),
        .has_modrm (lut_has_modrm),
        .imm_sz    (lut_imm_sz),
        .disp_sz   (lut_disp_sz),
        .aluk      (lut_aluk),
        .is_jmp    (lut_is_jmp),
        .opc_known (lut_known),
        .reg_ok    (lut_reg_ok)
    );

    // ModR/M decode of the incoming byte: SIB forms are not supported.
    assign sib = (in_byte[7:6] != 2'b11) && (in_byte[2:0] == 3'b100);

    always_comb begin
        modrm_disp_sz = SZ_NONE;
        unique case (in_byte[7:6])
            2'b00:   modrm_disp_sz = (in_byte[2:0] == 3'b101) ? SZ_32 : SZ_NONE;
            2'b01:   modrm_disp_sz = SZ_8;
            2'b10:   modrm_disp_sz = SZ_32;
            default: modrm_disp_sz = SZ_NONE;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        modrm_d    = modrm_q;
        disp_d     = disp_q;
        imm_d      = imm_q;
        disp_is8_d = disp_is8_q;
        imm_is8_d  = imm_is8_q;
        aluk_d     = aluk_q;
        is_jmp_d   = is_jmp_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        pend_imm_d = pend_imm_q;
`ifdef DECODE_ILLEGAL_EN
        illegal_d  = illegal_q;
`endif
        unique case (state_q)
            S_OPC: begin
                if (accept) begin
                    opcode_d   = in_byte;
                    modrm_d    = 8'h00;
                    disp_d     = 32'h0;
                    imm_d      = 32'h0;
                    disp_is8_d = 1'b0;
                    imm_is8_d  = 1'b0;
                    aluk_d     = ALU_ADD;
                    is_jmp_d   = 1'b0;
                    len_d      = 4'd1;
                    cnt_d      = SZ_NONE;
                    pend_imm_d = SZ_NONE;
`ifdef DECODE_ILLEGAL_EN
                    illegal_d  = 1'b0;
`endif
                    if (!lut_known) begin
`ifdef DECODE_ILLEGAL_EN
                        state_d   = S_OUT;
                        illegal_d = 1'b1;
`else
                        state_d   = S_OPC;
`endif
                    end else if (lut_has_modrm) begin
                        // aluk of group opcodes depends on ModR/M.reg
                        state_d    = S_MODRM;
                        pend_imm_d = lut_imm_sz;
                    end else begin
                        aluk_d   = lut_aluk;
                        is_jmp_d = lut_is_jmp;
                        if (lut_imm_sz != SZ_NONE) begin
                            state_d   = S_IMM;
                            cnt_d     = lut_imm_sz;
                            imm_is8_d = (lut_imm_sz == SZ_8);
                        end else if (lut_disp_sz != SZ_NONE) begin
                            state_d    = S_DISP;
                            cnt_d      = lut_disp_sz;
                            disp_is8_d = (lut_disp_sz == SZ_8);
                        end else begin
                            state_d = S_OUT;
                        end
                    end
                end
            end
            S_MODRM: begin
                if (accept) begin
                    modrm_d = in_byte;
                    len_d   = len_q + 4'd1;
                    if (!lut_reg_ok || sib) begin
`ifdef DECODE_ILLEGAL_EN
                        state_d   = S_OUT;
                        illegal_d = 1'b1;
`else
                        state_d   = S_OPC;
`endif
                    end else begin
                        aluk_d = lut_aluk;
                        if (modrm_disp_sz != SZ_NONE) begin
                            state_d    = S_DISP;
                            cnt_d      = modrm_disp_sz;
                            disp_is8_d = (modrm_disp_sz == SZ_8);
                        end else if (pend_imm_q != SZ_NONE) begin
                            state_d   = S_IMM;
                            cnt_d     = pend_imm_q;
                            imm_is8_d = (pend_imm_q == SZ_8);
                        end else begin
                            state_d = S_OUT;
                        end
                    end
                end
            end
            S_DISP: begin
                if (accept) begin
                    // Shift in from the top: little-endian bytes land in
                    // order, and a lone disp8 ends up in [31:24].
                    disp_d = {in_byte, disp_q[31:8]};
                    len_d  = len_q + 4'd1;
                    cnt_d  = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        if (pend_imm_q != SZ_NONE) begin
                            state_d   = S_IMM;
                            cnt_d     = pend_imm_q;
                            imm_is8_d = (pend_imm_q == SZ_8);
                        end else begin
                            state_d = S_OUT;
                        end
                    end
                end
            end
            S_IMM: begin
                if (accept) begin
                    imm_d = {in_byte, imm_q[31:8]};
                    len_d = len_q + 4'd1;
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_d = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_OPC;
                end
            end
            default: begin
                state_d = S_OPC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_OPC;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opcode_q   <= 8'h00;
            modrm_q    <= 8'h00;
            disp_q     <= 32'h0;
            imm_q      <= 32'h0;
            disp_is8_q <= 1'b0;
            imm_is8_q  <= 1'b0;
            aluk_q     <= ALU_ADD;
            is_jmp_q   <= 1'b0;
            len_q      <= 4'd0;
            cnt_q      <= SZ_NONE;
            pend_imm_q <= SZ_NONE;
`ifdef DECODE_ILLEGAL_EN
            illegal_q  <= 1'b0;
`endif
        end else begin
            opcode_q   <= opcode_d;
            modrm_q    <= modrm_d;
            disp_q     <= disp_d;
            imm_q      <= imm_d;
            disp_is8_q <= disp_is8_d;
            imm_is8_q  <= imm_is8_d;
            aluk_q     <= aluk_d;
            is_jmp_q   <= is_jmp_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            pend_imm_q <= pend_imm_d;
`ifdef DECODE_ILLEGAL_EN
            illegal_q  <= illegal_d;
`endif
        end
    end

    assign out_valid = (state_q == S_OUT);
    assign opcode    = opcode_q;
    assign modrm     = modrm_q;
    assign disp      = disp_q;
    assign imm       = imm_q;
    assign disp_is8  = disp_is8_q;
    assign imm_is8   = imm_is8_q;
    assign aluk      = aluk_q;
    assign is_jmp    = is_jmp_q;
    assign len       = len_q;
`ifdef DECODE_ILLEGAL_EN
    assign illegal   = illegal_q;
`endif

endmodule
